bin_to_bcd_seq: RTL and testbench
=================================

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 The block SHALL expose parameter NUM_DIGITS, default 6, number of BCD digits produced (fixed at 6 for the 6-digit display).
REQ-002 The block SHALL expose parameter BLANK_LEADING, default 1, where 1 replaces leading-zero digits with 4'hF.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, with reset synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1, a conversion request, sampled only while ready=1.
REQ-006 The block SHALL have port value, input, 20, an unsigned binary number, captured on the accepting edge.
REQ-007 The block SHALL have port ready, output, 1, high when idle and able to accept start.
REQ-008 The block SHALL have port done, output, 1, a one-cycle pulse marking a digits update.
REQ-009 The block SHALL have port overflow, output, 1, high when the last captured value exceeded 999999.
REQ-010 The block SHALL have port digits, output, 24, with digit k (k=0 ones) in bits [4k+3:4k]; each nibble drives one seven-segment decoder.

Function
REQ-011 The FSM SHALL have states IDLE, SHIFT, FORMAT and DONE.
REQ-012 In IDLE with start=1 on an edge, the block SHALL capture value, clear a 24-bit BCD scratch register, load a 5-bit shift counter with 20, and enter SHIFT; ready SHALL be high only in IDLE.
REQ-013 In SHIFT, each cycle the block SHALL first add 3 to every scratch nibble >= 5, then shift {scratch, binary} left by one and decrement the counter (double dabble).
REQ-014 After exactly 20 SHIFT cycles, the block SHALL enter FORMAT.
REQ-015 In FORMAT, the block SHALL register digits from scratch.
REQ-016 If BLANK_LEADING=1, each digit above the most significant nonzero digit SHALL become 4'hF, and digit 0 SHALL never be blanked.
REQ-017 The block SHALL then enter DONE.
REQ-018 In DONE, the block SHALL hold done=1 for exactly one cycle and then return to IDLE.
REQ-019 The digits update and the rising edge of done SHALL occur on the same clock edge.
REQ-020 Latency SHALL be fixed: done is high in the 22nd cycle after the accepting edge, and ready returns high in the cycle after done.
REQ-021 The digits outputs SHALL hold their previous values throughout SHIFT, with no intermediate values visible.
REQ-022 If captured value > 999999, overflow SHALL be set on the FORMAT edge and all digits SHALL be 4'hF.
REQ-023 Otherwise, overflow SHALL be cleared on the FORMAT edge.
REQ-024 The latency of an overflowing conversion SHALL be unchanged.
REQ-025 start while ready=0 SHALL be ignored, with no queueing and no effect on the conversion in progress.
REQ-026 The value input SHALL be ignored except on the accepting edge.
REQ-027 A start held continuously high SHALL produce back-to-back conversions, each accepted on the first IDLE cycle.
REQ-028 Valid range SHALL be 0..999999, and value 0 SHALL produce digit0=0.

Reset
REQ-029 When rst=1 on an edge, the FSM SHALL go to IDLE with ready=1, done=0, overflow=0, digits=24'hFFFFFF (blank display), and scratch and counter cleared.
REQ-030 rst SHALL take priority over start in the same cycle.
REQ-031 rst asserted mid-conversion SHALL abort the conversion with no done pulse and digits forced to 24'hFFFFFF.
REQ-032 The first start accepted after reset SHALL behave as a normal conversion.

Verification
REQ-033 The bench SHALL drive value=123456, start 1 cycle, and check digits=24'h123456, overflow=0, done high exactly 22 cycles after the accepting edge, and ready low throughout.
REQ-034 The bench SHALL drive value=42 with BLANK_LEADING=1 and check digits=24'hFFFF42; with BLANK_LEADING=0 it SHALL check digits=24'h000042.
REQ-035 The bench SHALL drive value=0 and check digits=24'hFFFFF0; it SHALL drive value=999999 and check digits=24'h999999 with overflow=0.
REQ-036 The bench SHALL drive value=1000000 and check overflow=1 and digits=24'hFFFFFF; a following conversion of 7 SHALL give overflow=0 and digits=24'hFFFFF7.
REQ-037 The bench SHALL convert 123456 and pulse start with value=5 at cycle 10; it SHALL check the result is 123456 with a single done, and digits unchanged until done.
REQ-038 The bench SHALL assert rst at cycle 8 of a conversion and check no done pulse, digits=24'hFFFFFF, ready=1 next cycle, and that a new conversion of 31 yields 24'hFFFF31.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
//
// Sequential 20-bit binary to BCD converter for a six-digit seven-segment
// display. A conversion is accepted while idle, runs the double-dabble
// algorithm one bit per clock, then formats the result (leading-zero blanking
// and overflow) and publishes it together with a one-cycle done pulse.
// Latency from the accepting edge to done is fixed at 22 cycles, overflowing
// conversions included.
//
// Handshake: start is a request that is only looked at while ready=1; the
// edge on which start=1 and ready=1 are both seen is the accepting edge and is
// the only edge on which value is captured. While ready=0 the block ignores
// start entirely (no queueing). done pulses high for exactly one cycle on the
// same edge that digits/overflow update.
//
// Parameters
//   NUM_DIGITS    : number of BCD digits produced (6 for this display)
//   BLANK_LEADING : 1 replaces digits above the most significant nonzero
//                   digit with 4'hF; digit 0 is never blanked
//
// Ports
//   clk       in   single clock, rising edge
//   rst       in   synchronous active-high reset, wins over start
//   start     in   conversion request
//   value     in   20-bit unsigned binary value
//   ready     out  high only while idle
//   done      out  one-cycle pulse, digits updated on the same edge
//   overflow  out  last captured value was above the displayable range
//   digits    out  digit k in bits [4k+3:4k], k=0 is the ones digit
//   dbg_state out  current FSM state (0 IDLE, 1 SHIFT, 2 FORMAT, 3 DONE)
// -----------------------------------------------------------------------------
module bin_to_bcd_seq #(
   parameter int NUM_DIGITS    = 6,
   parameter bit BLANK_LEADING = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [19:0]             value,
   output logic                    ready,
   output logic                    done,
   output logic                    overflow,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic [1:0]              dbg_state
);

   localparam int BCD_W = 4 * NUM_DIGITS;
   localparam int BIN_W = 20;

   // Largest value representable with NUM_DIGITS decimal digits.
   function automatic longint unsigned max_display(input int n);
      longint unsigned p;
      p = 64'd1;
      for (int i = 0; i < n; i++) begin
         p = p * 64'd10;
      end
      return p - 64'd1;
   endfunction

   localparam longint unsigned MAX_VAL = max_display(NUM_DIGITS);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
      S_FORMAT = 2'd2,
      S_DONE   = 2'd3
   } state_e;

   state_e             state_q;
   logic [BCD_W-1:0]   scratch_q;
   logic [BIN_W-1:0]   bin_q;
   logic [4:0]         cnt_q;
   logic               ovf_pend_q;
   logic               ready_q;
   logic               done_q;
   logic               overflow_q;
   logic [BCD_W-1:0]   digits_q;

   logic [BCD_W-1:0]   scratch_adj;
   logic [BCD_W-1:0]   scratch_d;
   logic [BIN_W-1:0]   bin_d;
   logic [BCD_W-1:0]   digits_d;
   logic               lead;

   // ---------------------------------------------------------------------------
   // Double-dabble step: correct every nibble that would carry past 9 after
   // doubling, then shift the whole {bcd, binary} word left by one.
   // ---------------------------------------------------------------------------
   always_comb begin
      scratch_adj = scratch_q;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (scratch_q[4*k +: 4] >= 4'd5) begin
            scratch_adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
         end
      end
      {scratch_d, bin_d} = {scratch_adj, bin_q} << 1;
   end

   // ---------------------------------------------------------------------------
   // Display formatting. Walk from the most significant digit downwards; while
   // every digit seen so far is zero the digit is blanked. The ones digit is
   // outside the loop so a value of 0 still shows a single 0.
   // ---------------------------------------------------------------------------
   always_comb begin
      digits_d = scratch_q;
      lead     = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         if (BLANK_LEADING && lead && (scratch_q[4*k +: 4] == 4'd0)) begin
            digits_d[4*k +: 4] = 4'hF;
         end else begin
            lead = 1'b0;
         end
      end
      if (ovf_pend_q) begin
         digits_d = '1;
      end
   end

   // ---------------------------------------------------------------------------
   // Control FSM and all registered outputs.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         scratch_q  <= '0;
         bin_q      <= '0;
         cnt_q      <= '0;
         ovf_pend_q <= 1'b0;
         ready_q    <= 1'b1;
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
         digits_q   <= '1;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  bin_q      <= value;
                  scratch_q  <= '0;
                  cnt_q      <= 5'd20;
                  // Decided at capture because bin_q is consumed by shifting.
                  ovf_pend_q <= ({44'd0, value} > MAX_VAL);
                  ready_q    <= 1'b0;
                  state_q    <= S_SHIFT;
               end
            end

            S_SHIFT: begin
               scratch_q <= scratch_d;
               bin_q     <= bin_d;
               cnt_q     <= cnt_q - 5'd1;
               // cnt_q==1 here means this is the 20th shift.
               if (cnt_q == 5'd1) begin
                  state_q <= S_FORMAT;
               end
            end

            S_FORMAT: begin
               digits_q   <= digits_d;
               overflow_q <= ovf_pend_q;
               done_q     <= 1'b1;
               state_q    <= S_DONE;
            end

            S_DONE: begin
               done_q  <= 1'b0;
               ready_q <= 1'b1;
               state_q <= S_IDLE;
            end

            default: begin
               state_q <= S_IDLE;
               ready_q <= 1'b1;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ready     = ready_q;
   assign done      = done_q;
   assign overflow  = overflow_q;
   assign digits    = digits_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd_seq
//
// Directed bench for bin_to_bcd_seq. Two instances share the stimulus: the
// default one (leading-zero blanking on) and one with blanking off, so every
// conversion is checked in both display formats.
// -----------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [19:0] value;

   logic        ready,  done,  overflow;
   logic [23:0] digits;
   logic [1:0]  dbg_state;

   logic        ready_nb, done_nb, overflow_nb;
   logic [23:0] digits_nb;
   logic [1:0]  dbg_state_nb;

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------------------------------------------------------- clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------- DUTs
   bin_to_bcd_seq #(.NUM_DIGITS(6), .BLANK_LEADING(1'b1)) dut (
      .clk(clk), .rst(rst), .start(start), .value(value),
      .ready(ready), .done(done), .overflow(overflow),
      .digits(digits), .dbg_state(dbg_state)
   );

   bin_to_bcd_seq #(.NUM_DIGITS(6), .BLANK_LEADING(1'b0)) dut_nb (
      .clk(clk), .rst(rst), .start(start), .value(value),
      .ready(ready_nb), .done(done_nb), .overflow(overflow_nb),
      .digits(digits_nb), .dbg_state(dbg_state_nb)
   );

   // ---------------------------------------------------------------- check
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Move to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (!ready && n < 60) begin
         tick();
         n++;
      end
      check({tag, "_wait_ready"}, 32'(ready), 32'd1);
   endtask

   // One full conversion. inject_cyc > 0 pulses start with value=5 during that
   // cycle of the conversion, which must be ignored.
   task automatic run_conv(input string tag, input logic [19:0] v,
                           input logic [23:0] exp_dig, input logic [23:0] exp_raw,
                           input logic exp_ovf, input int inject_cyc);
      logic [23:0] prev;
      int cyc, bad_ready, bad_hold;
      wait_ready(tag);
      start = 1'b1;
      value = v;
      tick();                           // accepting edge; now in cycle 1
      start = 1'b0;
      value = 20'($urandom_range(0, 20'hFFFFF));
      prev  = digits;
      cyc = 1; bad_ready = 0; bad_hold = 0;
      while (!done && cyc < 40) begin
         if (ready)          bad_ready++;
         if (digits !== prev) bad_hold++;
         if (inject_cyc > 0 && cyc == inject_cyc) begin
            start = 1'b1;
            value = 20'd5;
         end else begin
            start = 1'b0;
         end
         tick();
         cyc++;
      end
      start = 1'b0;
      check({tag, "_latency"},   32'(cyc), 32'd22);
      check({tag, "_ready_low"}, 32'(bad_ready), 32'd0);
      check({tag, "_hold"},      32'(bad_hold), 32'd0);
      check({tag, "_digits"},    32'(digits), 32'(exp_dig));
      check({tag, "_ovf"},       32'(overflow), 32'(exp_ovf));
      check({tag, "_digits_nb"}, 32'(digits_nb), 32'(exp_raw));
      tick();
      check({tag, "_done_1cyc"}, 32'(done), 32'd0);
      check({tag, "_ready_back"}, 32'(ready), 32'd1);
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      int cyc, gap, n_done;
      rst   = 1'b1;
      start = 1'b0;
      value = 20'd0;
      tick();
      start = 1'b1;                     // rst must win over start
      value = 20'd99;
      tick();
      check("rst_ready",    32'(ready), 32'd1);
      check("rst_done",     32'(done), 32'd0);
      check("rst_ovf",      32'(overflow), 32'd0);
      check("rst_digits",   32'(digits), 32'hFFFFFF);
      check("rst_state",    32'(dbg_state), 32'd0);
      start = 1'b0;
      rst   = 1'b0;
      tick();

      run_conv("c123456", 20'd123456,  24'h123456, 24'h123456, 1'b0, 0);
      run_conv("c42",     20'd42,      24'hFFFF42, 24'h000042, 1'b0, 0);
      run_conv("c0",      20'd0,       24'hFFFFF0, 24'h000000, 1'b0, 0);
      run_conv("c999999", 20'd999999,  24'h999999, 24'h999999, 1'b0, 0);
      run_conv("c1e6",    20'd1000000, 24'hFFFFFF, 24'hFFFFFF, 1'b1, 0);
      run_conv("c7",      20'd7,       24'hFFFFF7, 24'h000007, 1'b0, 0);
      run_conv("c100500", 20'd100500,  24'h100500, 24'h100500, 1'b0, 0);
      run_conv("cmax",    20'hFFFFF,   24'hFFFFFF, 24'hFFFFFF, 1'b1, 0);
      run_conv("c1000",   20'd1000,    24'hFF1000, 24'h001000, 1'b0, 0);

      // start during a conversion is ignored and not queued
      run_conv("cinj",    20'd123456,  24'h123456, 24'h123456, 1'b0, 10);
      tick();
      check("inj_no_queue", 32'(ready), 32'd1);

      // reset in the middle of a conversion
      wait_ready("rstmid");
      start = 1'b1;
      value = 20'd654321;
      tick();
      start = 1'b0;
      cyc = 1;
      n_done = 0;
      while (cyc < 8) begin
         if (done) n_done++;
         tick();
         cyc++;
      end
      rst = 1'b1;                       // asserted during cycle 8
      tick();
      rst = 1'b0;
      check("rstmid_done",   32'(done), 32'd0);
      check("rstmid_digits", 32'(digits), 32'hFFFFFF);
      check("rstmid_ready",  32'(ready), 32'd1);
      check("rstmid_ovf",    32'(overflow), 32'd0);
      for (int i = 0; i < 25; i++) begin
         if (done) n_done++;
         tick();
      end
      check("rstmid_no_done", 32'(n_done), 32'd0);
      check("rstmid_digits_kept", 32'(digits), 32'hFFFFFF);
      run_conv("c31", 20'd31, 24'hFFFF31, 24'h000031, 1'b0, 0);

      // start held high: back-to-back conversions, 23 cycles apart
      start = 1'b1;
      value = 20'd77;
      cyc = 0; gap = 0; n_done = 0;
      while (n_done < 2 && cyc < 100) begin
         tick();
         cyc++;
         if (n_done == 1) gap++;
         if (done) n_done++;
      end
      start = 1'b0;
      check("b2b_count",  32'(n_done), 32'd2);
      check("b2b_gap",    32'(gap), 32'd23);
      check("b2b_digits", 32'(digits), 32'hFFFF77);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
